counting_stim_gen: RTL
======================

Name: counting_stim_gen

Overview:
- Transmit end of the 2-bit symbol stream that `counting` consumes.
- Holds a software-loaded sequence of 2-bit symbols in a small buffer. On `start`, drives the sequence one symbol per clock on `num`, repeated N times with idle gaps between repeats.
- Feeds `counting.num` in system benches and in the ISE pre-lab top.
- Emits idle symbol 2'b00 whenever not sending. The detector holds its idle state on 2'b00.

Parameters:
- DEPTH, 8, maximum number of symbols in the sequence buffer (power of 2, ≥2).
- GAP_LEN, 2, number of idle 2'b00 cycles inserted between repeats (0 allowed).
- REP_W, 4, width of the repeat-count input.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  append `wr_data` to the buffer; honoured only in IDLE and when not full
- wr_data  in  2  symbol to append
- clr  in  1  empty the buffer; honoured only in IDLE
- start  in  1  begin transmission; honoured only in IDLE with len≠0 and repeat_cnt≠0
- repeat_cnt  in  REP_W  number of sequence passes, sampled when `start` is accepted
- num  out  2  transmitted symbol, registered
- num_valid  out  1  high while `num` carries a sequence symbol, registered
- busy  out  1  high in SEND or GAP
- done  out  1  one-cycle pulse after the last symbol of the last pass
- full  out  1  len == DEPTH
- len  out  $clog2(DEPTH)+1  current number of stored symbols

Behaviour:
- Clock and reset
  - One clock, `clk`. Reset `rst_n` is asynchronous and active-low.
  - While reset is asserted: state=IDLE, len=0, num=2'b00, num_valid=0, busy=0, done=0, and the read pointer and repeat counter are 0.
  - Buffer contents are don't-care after reset.
  - Reset asserted mid-transmission aborts it immediately. No `done` pulse is produced.
- States: IDLE, SEND, GAP. `done` is a registered pulse, not a state.
- IDLE
  - wr_en && !full: buf[len] ← wr_data, len+1. wr_en while full is ignored.
  - clr clears len to 0. clr takes priority over wr_en in the same cycle, and over start.
  - start with len≠0 && repeat_cnt≠0: load rep ← repeat_cnt, rptr ← 0, go to SEND. Otherwise start is ignored and state stays IDLE.
  - start and wr_en in the same cycle: the write completes first, and the transmission includes the new symbol.
- SEND
  - Each cycle: num ← buf[rptr], num_valid ← 1, rptr+1.
  - Latency: the first symbol appears on `num` in the cycle after the `start` edge.
  - When rptr == len-1:
    - If rep == 1: go to IDLE and pulse `done` in the cycle after the last symbol is driven (the same cycle num returns to 0).
    - Else if GAP_LEN == 0: go back to SEND with rptr ← 0 and rep−1. Passes are back-to-back.
    - Else: go to GAP with rep−1 and gap counter ← GAP_LEN.
- GAP
  - num ← 2'b00, num_valid ← 0 for exactly GAP_LEN cycles, then SEND with rptr ← 0.
- Ignored inputs outside IDLE: wr_en, clr and start are ignored in SEND and GAP. len and the buffer are frozen while busy.
- Width rules
  - rptr wraps naturally, but the limit is len-1, never DEPTH.
  - The repeat counter is REP_W bits. repeat_cnt = 2^REP_W−1 must complete exactly that many passes.
- Outputs
  - busy is combinational from state.
  - full and len reflect the stored count.
  - num_valid is never high in IDLE.

Decomposition:
- Shared package `counting_pkg` holds:
  - symbol width (2);
  - idle symbol constant 2'b00;
  - generator state encodings (IDLE/SEND/GAP), alongside the detector's S0–S3 codes so benches share one definition.
- One natural sub-module: `sym_buf`, a DEPTH×2 register file with write port, length counter and a combinational read at rptr. The FSM, counters and output registers live in the top.

Test Plan:
- Load 1,2,3, repeat_cnt=1, start:
  - num = 1,2,3 on the three cycles after start, num_valid high on those three cycles;
  - done pulses on the 4th cycle, num=0 there;
  - a `counting` instance on `num` reaches ans=1 after the third symbol edge.
- Load 1,3; repeat_cnt=3; GAP_LEN=2 → stream 1,3,0,0,1,3,0,0,1,3 then done. busy high for all 10 cycles.
- Fill 8 symbols, then wr_en with 2'b10 → full=1, len stays 8, the extra symbol is never transmitted.
- start with len=0 → no state change, busy=0, num stays 0. start with repeat_cnt=0 → same.
- Assert rst_n low during the 2nd symbol of a pass → num=0, num_valid=0, busy=0, len=0 asynchronously. No done pulse after release.
- wr_en=1 during SEND, and clr and start together in IDLE → the write is ignored, len unchanged; clr wins and start is not accepted (len becomes 0, busy stays 0).

Source files
------------

// File: rtl/counting_pkg.sv
// Shared definitions for the counting symbol stream: symbol width,
// idle symbol, generator state codes and the detector's S0-S3 codes.
package counting_pkg;

    localparam int SYM_W = 2;

    typedef logic [SYM_W-1:0] sym_t;

    localparam sym_t SYM_IDLE = 2'b00;

    typedef enum logic [1:0] {
        GEN_IDLE = 2'd0,
        GEN_SEND = 2'd1,
        GEN_GAP  = 2'd2
    } gen_state_t;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } det_state_t;

endpackage

// File: rtl/counting_stim_gen_if.sv
// Control/load and stream bundle of counting_stim_gen.
// master: loads and starts the generator; slave: the generator itself.
interface counting_stim_gen_if
    import counting_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int REP_W = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             wr_en;
    sym_t             wr_data;
    logic             clr;
    logic             start;
    logic [REP_W-1:0] repeat_cnt;
    sym_t             num;
    logic             num_valid;
    logic             busy;
    logic             done;
    logic             full;
    logic [LW-1:0]    len;

    modport master (
        output wr_en, wr_data, clr, start, repeat_cnt,
        input  num, num_valid, busy, done, full, len
    );

    modport slave (
        input  wr_en, wr_data, clr, start, repeat_cnt,
        output num, num_valid, busy, done, full, len
    );

endinterface

// File: rtl/counting_stim_gen_sym_buf.sv
// sym_buf: DEPTH x 2-bit symbol store with append port, length counter
// and combinational read. Ports: i_wr (qualified append), i_clr, i_wr_data,
// i_raddr -> o_rd_data, o_len, o_full.
module sym_buf
    import counting_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr,
    input  logic          i_clr,
    input  sym_t          i_wr_data,
    input  logic [AW-1:0] i_raddr,
    output sym_t          o_rd_data,
    output logic [LW-1:0] o_len,
    output logic          o_full
);

    sym_t          r_mem [DEPTH];
    logic [LW-1:0] r_len;

    // Contents are don't-care after reset, so the array has no reset.
    always_ff @(posedge clk) begin
        if (i_wr && !i_clr) begin
            r_mem[r_len[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len <= '0;
        end else if (i_clr) begin
            r_len <= '0;
        end else if (i_wr) begin
            r_len <= r_len + LW'(1);
        end
    end

    assign o_rd_data = r_mem[i_raddr];
    assign o_len     = r_len;
    assign o_full    = (r_len == LW'(DEPTH));

endmodule

// File: rtl/counting_stim_gen.sv
// Replays a loaded 2-bit symbol sequence on num, repeat_cnt times, with
// GAP_LEN idle cycles between passes. Ports: clk, rst_n, bus (slave).
module counting_stim_gen
    import counting_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int GAP_LEN = 2,
    parameter int REP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    counting_stim_gen_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

    gen_state_t       r_state, w_state_nx;
    logic [AW-1:0]    r_rptr, w_rptr_nx;
    logic [REP_W-1:0] r_rep, w_rep_nx;
    logic [GW-1:0]    r_gap, w_gap_nx;
    sym_t             r_num, w_num_nx;
    logic             r_valid, w_valid_nx;
    logic             r_done, w_done_nx;

    logic             w_idle;
    logic             w_wr;
    logic             w_clr;
    logic             w_last;
    logic [AW-1:0]    w_raddr;
    sym_t             w_rd;
    sym_t             w_first;
    logic [LW-1:0]    w_len;
    logic [LW-1:0]    w_len_eff;
    logic             w_full;

    assign w_idle = (r_state == GEN_IDLE);
    assign w_clr  = bus.clr && w_idle;
    assign w_wr   = bus.wr_en && w_idle && !bus.clr && !w_full;

    // r_rptr indexes the symbol currently shown on num, so the buffer
    // is read one ahead: the next index, or 0 when a pass restarts.
    assign w_last  = ({1'b0, r_rptr} == (w_len - LW'(1)));
    assign w_raddr = (r_state == GEN_SEND && !w_last)
                   ? r_rptr + AW'(1) : '0;

    // A same-cycle append is part of the sequence being started; only
    // slot 0 can be both written and needed now, when the buffer is empty.
    assign w_len_eff = w_len + LW'(w_wr);
    assign w_first   = (w_len == '0) ? bus.wr_data : w_rd;

    sym_buf #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr     (w_wr),
        .i_clr    (w_clr),
        .i_wr_data(bus.wr_data),
        .i_raddr  (w_raddr),
        .o_rd_data(w_rd),
        .o_len    (w_len),
        .o_full   (w_full)
    );

    always_comb begin
        w_state_nx = r_state;
        w_rptr_nx  = r_rptr;
        w_rep_nx   = r_rep;
        w_gap_nx   = r_gap;
        w_num_nx   = SYM_IDLE;
        w_valid_nx = 1'b0;
        w_done_nx  = 1'b0;
        unique case (r_state)
            GEN_IDLE: begin
                if (bus.start && !bus.clr && w_len_eff != '0
                    && bus.repeat_cnt != '0) begin
                    w_state_nx = GEN_SEND;
                    w_rptr_nx  = '0;
                    w_rep_nx   = bus.repeat_cnt;
                    w_num_nx   = w_first;
                    w_valid_nx = 1'b1;
                end
            end
            GEN_SEND: begin
                if (!w_last) begin
                    w_rptr_nx  = r_rptr + AW'(1);
                    w_num_nx   = w_rd;
                    w_valid_nx = 1'b1;
                end else if (r_rep == REP_W'(1)) begin
                    w_state_nx = GEN_IDLE;
                    w_rptr_nx  = '0;
                    w_rep_nx   = '0;
                    w_done_nx  = 1'b1;
                end else if (GAP_LEN == 0) begin
                    w_rptr_nx  = '0;
                    w_rep_nx   = r_rep - REP_W'(1);
                    w_num_nx   = w_rd;
                    w_valid_nx = 1'b1;
                end else begin
                    w_state_nx = GEN_GAP;
                    w_rep_nx   = r_rep - REP_W'(1);
                    w_gap_nx   = GW'(GAP_LEN);
                end
            end
            GEN_GAP: begin
                if (r_gap == GW'(1)) begin
                    w_state_nx = GEN_SEND;
                    w_rptr_nx  = '0;
                    w_num_nx   = w_rd;
                    w_valid_nx = 1'b1;
                end else begin
                    w_gap_nx = r_gap - GW'(1);
                end
            end
            default: begin
                w_state_nx = GEN_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= GEN_IDLE;
            r_rptr  <= '0;
            r_rep   <= '0;
            r_gap   <= '0;
            r_num   <= SYM_IDLE;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_rptr  <= w_rptr_nx;
            r_rep   <= w_rep_nx;
            r_gap   <= w_gap_nx;
            r_num   <= w_num_nx;
            r_valid <= w_valid_nx;
            r_done  <= w_done_nx;
        end
    end

    assign bus.num       = r_num;
    assign bus.num_valid = r_valid;
    assign bus.busy      = !w_idle;
    assign bus.done      = r_done;
    assign bus.full      = w_full;
    assign bus.len       = w_len;

endmodule
